// File: rtl/traffic_pkg.sv
// traffic_pkg: state codes, light codes, LED patterns and BCD helpers for the phase scheduler
package traffic_pkg;
  typedef enum logic [3:0] {
    G1 = 4'd0, G1F = 4'd1, Y1 = 4'd2, AR1 = 4'd3,
    G2 = 4'd4, G2F = 4'd5, Y2 = 4'd6, AR2 = 4'd7, NIGHT = 4'd8
  } state_t;
  localparam logic [1:0] MODE_GREEN  = 2'b00;
  localparam logic [1:0] MODE_FLASH  = 2'b01;
  localparam logic [1:0] MODE_YELLOW = 2'b10;
  localparam logic [1:0] MODE_RED    = 2'b11;
  localparam logic [5:0] LED_G1 = 6'b001_100;
  localparam logic [5:0] LED_Y1 = 6'b010_100;
  localparam logic [5:0] LED_AR = 6'b100_100;
  localparam logic [5:0] LED_G2 = 6'b100_001;
  localparam logic [5:0] LED_Y2 = 6'b100_010;
  function automatic logic [7:0] bcd_dec(logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction
  function automatic logic bcd_valid(logic [7:0] v);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9;
  endfunction
endpackage

// File: rtl/traffic_phase_sched_if.sv
// traffic_phase_sched_if: control inputs and light/countdown outputs of the phase scheduler
interface traffic_phase_sched_if;
  logic       tick;
  logic       day_night;
  logic [1:0] ped_req;
  logic [1:0] emerg;
  logic [5:0] light_led;
  logic [1:0] light_mode;
  logic [7:0] cnt;
  logic [3:0] phase;
  logic [1:0] ped_pend;
  modport master(output tick, day_night, ped_req, emerg,
                 input light_led, light_mode, cnt, phase, ped_pend);
  modport slave(input tick, day_night, ped_req, emerg,
                output light_led, light_mode, cnt, phase, ped_pend);
endinterface

// File: rtl/bcd_dn_cnt2.sv
// bcd_dn_cnt2: two-digit BCD down counter with parallel load
module bcd_dn_cnt2 import traffic_pkg::*; #(
  parameter logic [7:0] RST_VAL = 8'h25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= bcd_dec(cnt);
  end
endmodule

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: two-road phase FSM with pedestrian cut and night flash; TRAFFIC_EMERG_PREEMPT_EN adds emergency preemption
module traffic_phase_sched import traffic_pkg::*; #(
  parameter logic [7:0] GREEN_TIME  = 8'h25,
  parameter logic [7:0] FLASH_TIME  = 8'h04,
  parameter logic [7:0] YELLOW_TIME = 8'h03,
  parameter logic [7:0] ALLRED_TIME = 8'h02,
  parameter logic [7:0] PED_CUT     = 8'h05
) (
  input logic clk,
  input logic reset,
  traffic_phase_sched_if.slave bus
);
  if (!(bcd_valid(GREEN_TIME) && bcd_valid(FLASH_TIME) && bcd_valid(YELLOW_TIME) &&
        bcd_valid(ALLRED_TIME) && bcd_valid(PED_CUT) && GREEN_TIME != 8'h00 &&
        FLASH_TIME != 8'h00 && YELLOW_TIME != 8'h00 && ALLRED_TIME != 8'h00 &&
        PED_CUT != 8'h00)) begin : g_bad_param
    $error("traffic_phase_sched: phase times must be nonzero BCD");
  end
  state_t state, state_n, jump_to;
  logic flash_ph, flash_n, load, dec, emerg_jump, emerg_hold;
  logic [7:0] load_val, cnt;
  logic [1:0] ped_pend, pend_n;
  function automatic logic [7:0] dur(state_t s);
    return (s == G1 || s == G2) ? GREEN_TIME : (s == G1F || s == G2F) ? FLASH_TIME :
           (s == Y1 || s == Y2) ? YELLOW_TIME : (s == AR1 || s == AR2) ? ALLRED_TIME : 8'h00;
  endfunction
`ifdef TRAFFIC_EMERG_PREEMPT_EN
  // road-1 emergency wins over road-2 when both are asserted
  assign emerg_jump = (bus.emerg[0] && (state == G2 || state == G2F)) ||
                      (!bus.emerg[0] && bus.emerg[1] && (state == G1 || state == G1F));
  assign emerg_hold = (bus.emerg[0] && state == G1) || (bus.emerg[1] && state == G2);
  assign jump_to = (state == G2 || state == G2F) ? Y2 : Y1;
`else
  assign emerg_jump = 1'b0;
  assign emerg_hold = 1'b0;
  assign jump_to = Y1;
`endif
  always_comb begin
    state_n = state;
    load = 1'b0;
    load_val = 8'h00;
    dec = 1'b0;
    if (!bus.day_night) begin
      state_n = NIGHT;
      load = 1'b1;
    end else if (state == NIGHT) begin
      state_n = AR2;
      load = 1'b1;
      load_val = ALLRED_TIME;
    end else if (bus.tick) begin
      if (emerg_jump) begin
        state_n = jump_to;
        load = 1'b1;
        load_val = YELLOW_TIME;
      end else if (!emerg_hold) begin
        if (cnt == 8'h01) begin
          state_n = (state == AR2) ? G1 : state_t'(state + 4'd1);
          load = 1'b1;
          load_val = dur(state_n);
        end else if (((state == G1 && ped_pend[0]) || (state == G2 && ped_pend[1])) && cnt > PED_CUT) begin
          load = 1'b1;
          load_val = PED_CUT;
        end else dec = 1'b1;
      end
    end
  end
  // new requests are set after entry clears, so a same-cycle request survives
  assign pend_n = (state == NIGHT || state_n == NIGHT) ? 2'b00 :
                  (ped_pend & ~{state_n == Y2 && state != Y2, state_n == Y1 && state != Y1}) | bus.ped_req;
  assign flash_n = (state_n != state && (state_n == G1F || state_n == G2F || state_n == NIGHT)) ? 1'b1 :
                   (bus.tick && (state == G1F || state == G2F || state == NIGHT)) ? ~flash_ph : flash_ph;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= G1;
      flash_ph <= 1'b0;
      ped_pend <= 2'b00;
    end else begin
      state <= state_n;
      flash_ph <= flash_n;
      ped_pend <= pend_n;
    end
  end
  bcd_dn_cnt2 #(.RST_VAL(GREEN_TIME)) u_cnt (
    .clk(clk), .rst(reset), .load(load), .load_val(load_val), .dec(dec), .cnt(cnt)
  );
  assign bus.cnt = cnt;
  assign bus.phase = state;
  assign bus.ped_pend = ped_pend;
  assign bus.light_mode = (state == G1) ? MODE_GREEN : (state == G1F) ? MODE_FLASH :
                          (state == Y1) ? MODE_YELLOW : MODE_RED;
  assign bus.light_led = (state == G1) ? LED_G1 : (state == Y1) ? LED_Y1 :
                         (state == G2) ? LED_G2 : (state == Y2) ? LED_Y2 :
                         (state == G1F) ? {2'b00, flash_ph, 3'b100} :
                         (state == G2F) ? {5'b10000, flash_ph} :
                         (state == NIGHT) ? {1'b0, flash_ph, 2'b00, flash_ph, 1'b0} : LED_AR;
endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb_traffic_phase_sched: directed and random checks against an integer-time phase model
module tb_traffic_phase_sched;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  int ms = 0, mr = 25;
  bit mf = 1'b0;
  logic [1:0] mp = 2'b00;
  bit dn = 1'b1;
  traffic_phase_sched_if bus();
  traffic_phase_sched dut(.clk(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int dur(int s);
    case (s)
      0, 4: return 25;
      1, 5: return 4;
      2, 6: return 3;
      3, 7: return 2;
      default: return 0;
    endcase
  endfunction
  function automatic logic [7:0] bcd(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  function automatic logic [5:0] mled(int s, bit f);
    case (s)
      0: return 6'b001100;
      1: return {2'b00, f, 3'b100};
      2: return 6'b010100;
      3, 7: return 6'b100100;
      4: return 6'b100001;
      5: return {5'b10000, f};
      6: return 6'b100010;
      default: return {1'b0, f, 2'b00, f, 1'b0};
    endcase
  endfunction
  function automatic logic [1:0] mmode(int s);
    return (s == 0) ? 2'b00 : (s == 1) ? 2'b01 : (s == 2) ? 2'b10 : 2'b11;
  endfunction
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model(bit r, bit t, bit d, logic [1:0] q);
    int ns, nr;
    bit nf;
    logic [1:0] np, clr;
    if (r) begin
      ns = 0; nr = 25; nf = 0; np = 0;
    end else if (!d) begin
      ns = 8; nr = 0; np = 0;
      nf = (ms != 8) ? 1'b1 : (t ? ~mf : mf);
    end else if (ms == 8) begin
      ns = 7; nr = 2; np = 0; nf = mf;
    end else begin
      ns = ms; nr = mr;
      if (t) begin
        if (mr == 1) begin
          ns = (ms == 7) ? 0 : ms + 1;
          nr = dur(ns);
        end else if (((ms == 0 && mp[0]) || (ms == 4 && mp[1])) && mr > 5) nr = 5;
        else nr = mr - 1;
      end
      clr = {ns == 6 && ms != 6, ns == 2 && ms != 2};
      np = (mp & ~clr) | q;
      nf = (ns != ms && (ns == 1 || ns == 5)) ? 1'b1 : (t && (ms == 1 || ms == 5)) ? ~mf : mf;
    end
    ms = ns; mr = nr; mf = nf; mp = np;
  endtask
  task automatic cyc(bit r, bit t, bit d, logic [1:0] q);
    @(negedge clk);
    rst = r; bus.tick = t; bus.day_night = d; bus.ped_req = q;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    bus.emerg = 2'b00;
`else
    bus.emerg = 2'($urandom_range(0, 3));
`endif
    model(r, t, d, q);
    @(posedge clk);
    #1;
    chk("phase", 8'(bus.phase), 8'(ms));
    chk("cnt", bus.cnt, bcd(mr));
    chk("led", 8'(bus.light_led), 8'(mled(ms, mf)));
    chk("mode", 8'(bus.light_mode), 8'(mmode(ms)));
    chk("pend", 8'(bus.ped_pend), 8'(mp));
  endtask
  task automatic run_until(int s, int r);
    int k = 0;
    while (!(ms == s && mr == r) && k < 400) begin
      cyc(0, 1, 1, 2'b00);
      k++;
    end
    chk("reach_target", 8'(k < 400), 8'd1);
  endtask
  initial begin
    bus.tick = 0; bus.day_night = 1; bus.ped_req = 0; bus.emerg = 0;
    cyc(1, 0, 1, 2'b00);
    cyc(1, 0, 1, 2'b00);
    chk("reset_cnt", bus.cnt, 8'h25);
    chk("reset_led", 8'(bus.light_led), 8'b001100);
    for (int i = 0; i < 68 * 16; i++) cyc(0, i % 16 == 15, 1, 2'b00);
    chk("full_cycle_phase", 8'(bus.phase), 8'h00);
    chk("full_cycle_cnt", bus.cnt, 8'h25);
    run_until(0, 18);
    cyc(0, 0, 1, 2'b01);
    chk("ped_latched", 8'(bus.ped_pend), 8'h01);
    cyc(0, 1, 1, 2'b00);
    chk("ped_cut", bus.cnt, 8'h05);
    run_until(2, 3);
    chk("ped_clr_y1", 8'(bus.ped_pend), 8'h00);
    run_until(0, 4);
    cyc(0, 0, 1, 2'b01);
    cyc(0, 1, 1, 2'b00);
    chk("ped_no_cut", bus.cnt, 8'h03);
    run_until(4, 12);
    cyc(0, 0, 0, 2'b00);
    chk("night_phase", 8'(bus.phase), 8'h08);
    chk("night_cnt", bus.cnt, 8'h00);
    chk("night_led_on", 8'(bus.light_led), 8'b010010);
    cyc(0, 1, 0, 2'b11);
    chk("night_led_off", 8'(bus.light_led), 8'h00);
    cyc(0, 1, 0, 2'b00);
    cyc(0, 0, 1, 2'b00);
    chk("night_exit_phase", 8'(bus.phase), 8'h07);
    chk("night_exit_cnt", bus.cnt, 8'h02);
    cyc(0, 1, 1, 2'b00);
    cyc(0, 1, 1, 2'b00);
    chk("after_night_cnt", bus.cnt, 8'h25);
    run_until(6, 2);
    cyc(1, 0, 1, 2'b00);
    chk("reset_y2_phase", 8'(bus.phase), 8'h00);
    chk("reset_y2_cnt", bus.cnt, 8'h25);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) dn = ~dn;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, dn,
          ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'b00);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
